// File: rtl/address_sequencer.sv
// Address sequencer: steps a registered address from a latched start to a latched end
// by a latched stride, advancing once per rising edge of done_i; one-shot or looping.
module address_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int STRIDE_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                done_i,
  input  logic [ADDR_W-1:0]   start_addr_i,
  input  logic [ADDR_W-1:0]   end_addr_i,
  input  logic [STRIDE_W-1:0] stride_i,
  input  logic                loop_mode_i,
  output logic [ADDR_W-1:0]   address_o,
  output logic                busy_o,
  output logic                wrap_o,
  output logic                complete_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic                enable_q, done_q;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;
  logic                complete_q, complete_d;

  logic                enable_rise, done_rise;
  logic [STRIDE_W-1:0] stride_eff;
  logic [ADDR_W:0]     next_addr;
  logic                in_range;

  assign enable_rise = enable_i & ~enable_q;
  assign done_rise   = done_i & ~done_q;

  // A zero stride would stall the sequence forever, so it steps by one instead.
  assign stride_eff = (stride_q == '0) ? STRIDE_W'(1) : stride_q;
  assign next_addr  = {1'b0, addr_q} + (ADDR_W + 1)'(stride_eff);
  assign in_range   = ~next_addr[ADDR_W] && (next_addr[ADDR_W-1:0] <= end_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= '0;
      end_q      <= '0;
      stride_q   <= '0;
      loop_q     <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_i;
      done_q     <= done_i;
      start_q    <= start_d;
      end_q      <= end_d;
      stride_q   <= stride_d;
      loop_q     <= loop_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      complete_q <= complete_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    stride_d   = stride_q;
    loop_d     = loop_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    wrap_d     = 1'b0;
    complete_d = 1'b0;

    // An enable rise restarts from either state and swallows a coincident done rise.
    if (enable_rise) begin
      start_d  = start_addr_i;
      end_d    = end_addr_i;
      stride_d = stride_i;
      loop_d   = loop_mode_i;
      addr_d   = start_addr_i;
      busy_d   = 1'b1;
      state_d  = RUN;
    end else if (state_q == RUN && done_rise) begin
      if (in_range) begin
        addr_d = next_addr[ADDR_W-1:0];
      end else if (loop_q) begin
        addr_d = start_q;
        wrap_d = 1'b1;
      end else begin
        complete_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    end
  end

  assign address_o  = addr_q;
  assign busy_o     = busy_q;
  assign wrap_o     = wrap_q;
  assign complete_o = complete_q;

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer: one-shot, loop, overflow, stride-0, done-level
// handling, restart priority and asynchronous reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_address_sequencer;
  localparam int ADDR_W   = 16;
  localparam int STRIDE_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable, done, loop_mode;
  logic [ADDR_W-1:0]   start_addr, end_addr;
  logic [STRIDE_W-1:0] stride;
  logic [ADDR_W-1:0]   address;
  logic                busy, wrap, complete;

  int checks   = 0;
  int failures = 0;

  address_sequencer #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .done_i(done),
    .start_addr_i(start_addr), .end_addr_i(end_addr), .stride_i(stride),
    .loop_mode_i(loop_mode), .address_o(address), .busy_o(busy),
    .wrap_o(wrap), .complete_o(complete)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] a, input logic b,
                           input logic w, input logic c);
    chk({tag, ".addr"}, 32'(address), 32'(a));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".complete"}, 32'(complete), 32'(c));
    $display("step %s: addr=0x%04h busy=%0b wrap=%0b complete=%0b", tag, address, busy, wrap, complete);
  endtask

  task automatic config_run(input logic [15:0] s, input logic [15:0] e,
                            input logic [7:0] st, input logic lp);
    start_addr = s; end_addr = e; stride = st; loop_mode = lp;
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Raise done for one sampled cycle; the caller checks the result, then it drops.
  task automatic done_rise();
    done = 1'b1;
    tick();
  endtask

  task automatic done_fall();
    done = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; done = 1'b0; loop_mode = 1'b0;
    start_addr = '0; end_addr = '0; stride = '0;
    #3;
    chk_state("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    #9 rst = 1'b0;
    tick();

    // One-shot 0x10..0x13 stride 1
    config_run(16'h0010, 16'h0013, 8'd1, 1'b0);
    chk_state("os.start", 16'h0010, 1'b1, 1'b0, 1'b0);
    done_rise(); chk_state("os.r1", 16'h0011, 1'b1, 1'b0, 1'b0); done_fall();
    done_rise(); chk_state("os.r2", 16'h0012, 1'b1, 1'b0, 1'b0); done_fall();
    done_rise(); chk_state("os.r3", 16'h0013, 1'b1, 1'b0, 1'b0); done_fall();
    done_rise(); chk_state("os.end", 16'h0013, 1'b0, 1'b0, 1'b1);
    done_fall(); chk_state("os.pulse_off", 16'h0013, 1'b0, 1'b0, 1'b0);
    done_rise(); chk_state("idle.done", 16'h0013, 1'b0, 1'b0, 1'b0); done_fall();

    // Loop 0..5 stride 2
    config_run(16'h0000, 16'h0005, 8'd2, 1'b1);
    chk_state("lp.start", 16'h0000, 1'b1, 1'b0, 1'b0);
    done_rise(); chk_state("lp.r1", 16'h0002, 1'b1, 1'b0, 1'b0); done_fall();
    done_rise(); chk_state("lp.r2", 16'h0004, 1'b1, 1'b0, 1'b0); done_fall();
    done_rise(); chk_state("lp.wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    done_fall(); chk_state("lp.wrap_off", 16'h0000, 1'b1, 1'b0, 1'b0);
    done_rise(); done_fall();
    done_rise(); chk_state("lp.at4", 16'h0004, 1'b1, 1'b0, 1'b0); done_fall();

    // Restart wins over a coincident done rise; new start beyond end
    start_addr = 16'h0100; enable = 1'b1; done = 1'b1;
    tick();
    chk_state("restart", 16'h0100, 1'b1, 1'b0, 1'b0);
    enable = 1'b0; done_fall();
    done_rise(); chk_state("restart.reload", 16'h0100, 1'b1, 1'b1, 1'b0); done_fall();

    // Carry out of the address width terminates instead of wrapping
    config_run(16'hFFF0, 16'hFFFF, 8'h20, 1'b0);
    chk_state("ovf.start", 16'hFFF0, 1'b1, 1'b0, 1'b0);
    done_rise(); chk_state("ovf.end", 16'hFFF0, 1'b0, 1'b0, 1'b1); done_fall();

    // Stride 0 acts as 1; inputs changed mid-run are ignored
    config_run(16'h0003, 16'h0010, 8'd0, 1'b0);
    done_rise(); chk_state("s0.r1", 16'h0004, 1'b1, 1'b0, 1'b0); done_fall();
    stride = 8'd5; end_addr = 16'h0000; start_addr = 16'h0200; loop_mode = 1'b1;
    done_rise(); chk_state("s0.latched", 16'h0005, 1'b1, 1'b0, 1'b0);

    // done held high for 100 cycles advances only once
    done_fall();
    done = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk_state("held", 16'h0006, 1'b1, 1'b0, 1'b0);
    done_fall();

    // 300-cycle square wave: one advance per rising edge
    config_run(16'h0000, 16'hFFFF, 8'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      done = 1'b1;
      for (int k = 0; k < 15; k++) tick();
      done = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      chk($sformatf("sq.%0d", i), 32'(address), 32'(i + 1));
    end
    $display("step square: addr=0x%04h", address);

    // Asynchronous reset mid-run at 0x0012
    config_run(16'h0010, 16'h0020, 8'd1, 1'b0);
    done_rise(); done_fall();
    done_rise(); chk_state("rst.pre", 16'h0012, 1'b1, 1'b0, 1'b0); done_fall();
    #2 rst = 1'b1;
    #1 chk_state("rst.async", 16'h0000, 1'b0, 1'b0, 1'b0);
    start_addr = 16'h0040; end_addr = 16'h0050; stride = 8'd1; loop_mode = 1'b0;
    enable = 1'b1;
    tick();
    chk_state("rst.held", 16'h0000, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk_state("rst.enable_high", 16'h0040, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    tick();
    chk_state("rst.enable_fall", 16'h0040, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
